i281_fetch_decode: RTL
======================

Name: i281_fetch_decode

Overview:
- Reader and decoder for the i281 16-word instruction image. Consumes the 16 parallel 16-bit code-memory words b0I..b15I (format: opcode[15:12], rx[11:10], ry[9:8], imm[7:0]).
- Holds the PC and fetches one word per cycle. Splits each word into fields and class flags in a registered output stage, with a valid/ready handshake toward execute.
- Resolves unconditional JUMP locally. Accepts an external redirect for taken branches.

Parameters:
- RESET_PC, 4'd0, PC value loaded on reset.
- HALT_ON_SELF_JUMP, 1, when 1 a JUMP with imm=8'hFF (jump-to-self) stops fetching and asserts halted.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- b0I..b15I  input  16 each  code memory words; index = PC.
- run  input  1  fetch enable.
- redirect_valid  input  1  taken branch from execute.
- redirect_pc  input  4  branch target.
- out_ready  input  1  execute accepts current decoded word.
- out_valid  output  1  decoded word valid.
- out_pc  output  4  PC of the decoded word.
- opcode  output  4  instr[15:12].
- rx  output  2  instr[11:10].
- ry  output  2  instr[9:8].
- imm  output  8  instr[7:0].
- is_jump  output  1  opcode 1110.
- is_branch  output  1  opcode 1111.
- mem_rd  output  1  opcode 1000 or 1001.
- mem_wr  output  1  opcode 1010 or 1011.
- reg_wr  output  1  opcodes 0001, 0010, 0011, 0100, 0101, 0110, 0111, 1000, 1001, 1100.
- halted  output  1  fetch stopped on self-jump.
- pc  output  4  current fetch PC.

Behaviour:
- Reset (async, Reset_n=0):
  - pc=RESET_PC.
  - out_valid=0, all field and flag outputs 0, halted=0, FSM=S_IDLE.
  - Reset mid-handshake discards the held word.
- FSM states:
  - S_IDLE: run=0. No fetch. A held valid word stays until accepted.
  - S_RUN: one fetch per cycle when the output stage is free.
  - S_HALT: stopped.
- Transitions:
  - S_IDLE->S_RUN when run=1.
  - S_RUN->S_IDLE when run=0.
  - S_RUN->S_HALT when a self-jump is loaded and HALT_ON_SELF_JUMP=1.
  - S_HALT->S_RUN only on redirect_valid.
- Output stage free = !out_valid || out_ready.
- Fetch, in S_RUN and free: on the clock edge, load out_* from word b[pc] combinationally selected, set out_valid=1, out_pc=pc.
- Next PC:
  - Fetched word is JUMP (opcode 1110): pc <= pc + 1 + imm[3:0], 4-bit modulo wrap, sign of imm ignored beyond 4 bits.
  - Otherwise: pc <= pc + 1, wrap 15->0.
- Accepted with no new fetch: out_valid=1 && out_ready=1 and no fetch this cycle -> out_valid <= 0.
- Stall: out_valid=1 && out_ready=0 -> outputs and pc held unchanged.
- Latency: word at pc appears on outputs 1 cycle after the fetch edge. Sustained throughput is 1 word/cycle with out_ready=1.
- Redirect has highest priority, same cycle as anything else:
  - out_valid <= 0 (flush, even if stalled or accepting).
  - pc <= redirect_pc, halted <= 0, FSM <= (run ? S_RUN : S_IDLE).
  - First word from the target is valid 2 edges after the redirect edge (flush, then fetch).
- Self-jump: JUMP with imm=8'hFF is still emitted (out_valid=1, is_jump=1). Same edge sets halted=1 and FSM=S_HALT. pc holds the jump's own address.
- Conditional branches (1111) are not predicted; fetch continues at pc+1 until redirect.
- run deasserted while a word is held: the word is still presented until accepted; no further fetches.
- Class flags are decoded from the opcode only; rx/ry/imm pass through unmodified.

Decomposition:
- Shared package i281_pkg:
  - opcode localparams (OP_NOOP=0 ... OP_JUMP=4'hE, OP_BRANCH=4'hF).
  - FSM state encoding.
  - field bit positions.
- One sub-module, i281_instr_decode: purely combinational, word -> opcode/rx/ry/imm/flags. It is reused by the debug display path.
- The top level holds the PC, the FSM and the output register.

Test Plan:
- Reset release, run=1, out_ready=1, b0I=16'h3C02 -> cycle 1: out_valid=1, out_pc=0, opcode=3, rx=3, ry=0, imm=8'h02, reg_wr=1.
- Stream 16 words with out_ready=1 -> out_pc 0..15 then 0 (wrap). b11I=16'hF101 gives is_branch=1, ry=1, imm=1. b13I=16'h8C0C gives mem_rd=1.
- b5I=16'hE003 -> after out_pc=5 (is_jump=1), next out_pc=9. b15I=16'hE001 -> next out_pc=1 (wrap).
- out_ready=0 for 3 cycles while out_pc=4 -> all outputs and pc frozen. First cycle after out_ready=1 shows out_pc=5.
- redirect_valid=1, redirect_pc=12 during a stall -> next cycle out_valid=0. Following cycle out_pc=12, word b12I=16'h3400.
- b7I=16'hE0FF -> out_pc=7 emitted with is_jump=1, halted=1, no further out_valid. Redirect to 0 -> halted=0, fetch resumes at 0.

Source files
------------

// File: rtl/i281_pkg.sv
// rtl/i281_pkg.sv - i281 opcodes, instruction field positions, fetch FSM states and decoded-word type
package i281_pkg;

    localparam logic [3:0] OP_NOOP   = 4'h0;
    localparam logic [3:0] OP_INPUT  = 4'h1;
    localparam logic [3:0] OP_MOVE   = 4'h2;
    localparam logic [3:0] OP_LOADI  = 4'h3;
    localparam logic [3:0] OP_ADD    = 4'h4;
    localparam logic [3:0] OP_ADDI   = 4'h5;
    localparam logic [3:0] OP_SUB    = 4'h6;
    localparam logic [3:0] OP_SUBI   = 4'h7;
    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_LOADF  = 4'h9;
    localparam logic [3:0] OP_STORE  = 4'hA;
    localparam logic [3:0] OP_STOREF = 4'hB;
    localparam logic [3:0] OP_SHIFT  = 4'hC;
    localparam logic [3:0] OP_CMP    = 4'hD;
    localparam logic [3:0] OP_JUMP   = 4'hE;
    localparam logic [3:0] OP_BRANCH = 4'hF;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RX_MSB  = 11;
    localparam int RX_LSB  = 10;
    localparam int RY_MSB  = 9;
    localparam int RY_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Jump offset that lands back on the jump itself (pc + 1 - 1)
    localparam logic [7:0] IMM_SELF = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] rx;
        logic [1:0] ry;
        logic [7:0] imm;
        logic       is_jump;
        logic       is_branch;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
    } decoded_t;

endpackage

// File: rtl/i281_instr_decode.sv
// rtl/i281_instr_decode.sv - combinational split of one i281 word into fields and class flags
module i281_instr_decode
    import i281_pkg::*;
(
    input  logic [15:0] instr,
    output decoded_t    dec
);

    always_comb begin
        dec        = '0;
        dec.opcode = instr[OPC_MSB:OPC_LSB];
        dec.rx     = instr[RX_MSB:RX_LSB];
        dec.ry     = instr[RY_MSB:RY_LSB];
        dec.imm    = instr[IMM_MSB:IMM_LSB];
        case (instr[OPC_MSB:OPC_LSB])
            OP_INPUT, OP_MOVE, OP_LOADI, OP_ADD,
            OP_ADDI, OP_SUB, OP_SUBI, OP_SHIFT: dec.reg_wr = 1'b1;
            OP_LOAD, OP_LOADF: begin
                dec.mem_rd = 1'b1;
                dec.reg_wr = 1'b1;
            end
            OP_STORE, OP_STOREF: dec.mem_wr    = 1'b1;
            OP_JUMP:             dec.is_jump   = 1'b1;
            OP_BRANCH:           dec.is_branch = 1'b1;
            OP_NOOP, OP_CMP:     dec.reg_wr    = 1'b0;
            default:             dec.reg_wr    = 1'b0;
        endcase
    end

endmodule

// File: rtl/i281_fetch_decode.sv
// rtl/i281_fetch_decode.sv - i281 PC, fetch FSM and registered decode stage with valid/ready toward execute
module i281_fetch_decode
    import i281_pkg::*;
#(
    parameter logic [3:0] RESET_PC          = 4'd0,
    parameter bit         HALT_ON_SELF_JUMP = 1'b1
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [15:0] b0I,
    input  logic [15:0] b1I,
    input  logic [15:0] b2I,
    input  logic [15:0] b3I,
    input  logic [15:0] b4I,
    input  logic [15:0] b5I,
    input  logic [15:0] b6I,
    input  logic [15:0] b7I,
    input  logic [15:0] b8I,
    input  logic [15:0] b9I,
    input  logic [15:0] b10I,
    input  logic [15:0] b11I,
    input  logic [15:0] b12I,
    input  logic [15:0] b13I,
    input  logic [15:0] b14I,
    input  logic [15:0] b15I,
    input  logic        run,
    input  logic        redirect_valid,
    input  logic [3:0]  redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [3:0]  out_pc,
    output logic [3:0]  opcode,
    output logic [1:0]  rx,
    output logic [1:0]  ry,
    output logic [7:0]  imm,
    output logic        is_jump,
    output logic        is_branch,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        reg_wr,
    output logic        halted,
    output logic [3:0]  pc
);

    state_e      state_q, state_d;
    logic [3:0]  pc_q, pc_d;
    decoded_t    out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic [3:0]  out_pc_q, out_pc_d;
    logic        halted_q, halted_d;

    logic [15:0] words [16];
    logic [15:0] fetch_word;
    decoded_t    fetch_dec;
    logic        stage_free;
    logic        fetch_en;
    logic        self_jump;

    assign words[0]  = b0I;
    assign words[1]  = b1I;
    assign words[2]  = b2I;
    assign words[3]  = b3I;
    assign words[4]  = b4I;
    assign words[5]  = b5I;
    assign words[6]  = b6I;
    assign words[7]  = b7I;
    assign words[8]  = b8I;
    assign words[9]  = b9I;
    assign words[10] = b10I;
    assign words[11] = b11I;
    assign words[12] = b12I;
    assign words[13] = b13I;
    assign words[14] = b14I;
    assign words[15] = b15I;

    assign fetch_word = words[pc_q];

    i281_instr_decode u_decode (
        .instr (fetch_word),
        .dec   (fetch_dec)
    );

    // Fetch follows run directly so the first word leaves on the edge that sees run rise
    assign stage_free = !out_valid_q || out_ready;
    assign fetch_en   = run && stage_free && (state_q != S_HALT);
    assign self_jump  = HALT_ON_SELF_JUMP && fetch_dec.is_jump && (fetch_dec.imm == IMM_SELF);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        halted_d    = halted_q;

        case (state_q)
            S_IDLE:  if (run) state_d = S_RUN;
            S_RUN:   if (!run) state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (fetch_en) begin
            out_d       = fetch_dec;
            out_valid_d = 1'b1;
            out_pc_d    = pc_q;
            if (self_jump) begin
                halted_d = 1'b1;
                state_d  = S_HALT;
            end else if (fetch_dec.is_jump) begin
                pc_d = pc_q + 4'd1 + fetch_dec.imm[3:0];
            end else begin
                pc_d = pc_q + 4'd1;
            end
        end

        if (redirect_valid) begin
            out_valid_d = 1'b0;
            pc_d        = redirect_pc;
            halted_d    = 1'b0;
            state_d     = run ? S_RUN : S_IDLE;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= 4'd0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            halted_q    <= halted_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign opcode    = out_q.opcode;
    assign rx        = out_q.rx;
    assign ry        = out_q.ry;
    assign imm       = out_q.imm;
    assign is_jump   = out_q.is_jump;
    assign is_branch = out_q.is_branch;
    assign mem_rd    = out_q.mem_rd;
    assign mem_wr    = out_q.mem_wr;
    assign reg_wr    = out_q.reg_wr;
    assign halted    = halted_q;
    assign pc        = pc_q;

endmodule
